// File: rtl/mc_datapath.sv
// Multi-cycle RV32I/RV64I datapath: FETCH/DECODE/EXEC/MEM/WB sequencing with
// handshaked instruction and data memories and an external decode controller.
module mc_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ready,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [31:0]      ir_out,
  output logic [2:0]       state_out,
  input  logic [3:0]       ALU_Control,
  input  logic [2:0]       ImmSel,
  input  logic [1:0]       MemtoReg,
  input  logic             ALUSrc_B,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             InverseBranch,
  input  logic             PCOffset,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [XLEN-1:0]  pc_out,
  output logic             misalign_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  input  logic [4:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   imem_req_nxt, dmem_req_nxt, dmem_we_nxt;

  logic [XLEN-1:0] pc, a, b, imm, alu_out, mdr, target, pc_plus4, link;
  logic [31:0]     ir;
  logic            take;
  logic [XLEN-1:0] regs [32];

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext, opb, alu_res, tgt_raw, rs1_val, rs2_val, wb_val;
  logic [SHW-1:0]  shamt;
  logic            zero, fetch_done, mem_done;

  assign fetch_done = (state == S_FETCH) && imem_req && imem_ready;
  assign mem_done   = (state == S_MEM) && dmem_req && dmem_ready;

  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b;
  assign ir_out     = ir;
  assign state_out  = state;
  assign dbg_data   = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
  assign rs1_val    = (ir[19:15] == 5'd0) ? '0 : regs[ir[19:15]];
  assign rs2_val    = (ir[24:20] == 5'd0) ? '0 : regs[ir[24:20]];

  // Immediate generator, sign-extended from 32 bits to XLEN
  always_comb begin
    imm32 = '0;
    case (ImmSel)
      3'd0:    imm32 = {{20{ir[31]}}, ir[31:20]};
      3'd1:    imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      3'd2:    imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      3'd3:    imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      3'd4:    imm32 = {ir[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  assign opb   = ALUSrc_B ? imm : b;
  assign shamt = opb[SHW-1:0];

  // ALU; undefined control codes produce zero
  always_comb begin
    alu_res = '0;
    case (ALU_Control)
      4'd0:    alu_res = a + opb;
      4'd1:    alu_res = a - opb;
      4'd2:    alu_res = a & opb;
      4'd3:    alu_res = a | opb;
      4'd4:    alu_res = a ^ opb;
      4'd5:    alu_res = a << shamt;
      4'd6:    alu_res = a >> shamt;
      4'd7:    alu_res = XLEN'($signed(a) >>> shamt);
      4'd8:    alu_res = XLEN'($signed(a) < $signed(opb));
      4'd9:    alu_res = XLEN'(a < opb);
      default: alu_res = '0;
    endcase
  end

  assign zero    = (alu_res == '0);
  assign tgt_raw = PCOffset ? (pc + imm) : alu_res;

  // Write-back source select
  always_comb begin
    wb_val = alu_out;
    case (MemtoReg)
      2'd0:    wb_val = alu_out;
      2'd1:    wb_val = mdr;
      2'd2:    wb_val = link;
      default: wb_val = imm;
    endcase
  end

  // Next-state and registered-request decode
  always_comb begin
    state_nxt    = state;
    imem_req_nxt = 1'b0;
    dmem_req_nxt = 1'b0;
    dmem_we_nxt  = 1'b0;
    case (state)
      S_FETCH: begin
        if (fetch_done) state_nxt = S_DECODE;
        else            imem_req_nxt = 1'b1;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (MemRead || MemWrite) begin
          state_nxt    = S_MEM;
          dmem_req_nxt = 1'b1;
          dmem_we_nxt  = MemWrite;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_done) begin
          state_nxt = S_WB;
        end else begin
          dmem_req_nxt = 1'b1;
          dmem_we_nxt  = dmem_we;
        end
      end
      S_WB: begin
        state_nxt    = S_FETCH;
        imem_req_nxt = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State register and memory request flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
    end else begin
      state    <= state_nxt;
      imem_req <= imem_req_nxt;
      dmem_req <= dmem_req_nxt;
      dmem_we  <= dmem_we_nxt;
    end
  end

  // Datapath registers, PC, status and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      imm          <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      target       <= '0;
      pc_plus4     <= '0;
      link         <= '0;
      take         <= 1'b0;
      misalign_err <= 1'b0;
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (fetch_done) ir <= imem_rdata;
      if (state == S_DECODE) begin
        a   <= rs1_val;
        b   <= rs2_val;
        imm <= imm_ext;
      end
      if (state == S_EXEC) begin
        alu_out  <= alu_res;
        pc_plus4 <= pc + XLEN'(4);
        target   <= {tgt_raw[XLEN-1:1], 1'b0};
        link     <= Jump ? (pc + XLEN'(4)) : (pc + imm);
        take     <= Jump | (Branch & (InverseBranch ? ~zero : zero));
      end
      if (mem_done && MemRead) mdr <= dmem_rdata;
      if (state == S_WB) begin
        pc          <= take ? target : pc_plus4;
        instret_cnt <= instret_cnt + CNT_W'(1);
        if (take && target[1]) misalign_err <= 1'b1;
      end
    end
  end

  // Register file; x0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == S_WB && RegWrite && ir[11:7] != 5'd0) begin
      regs[ir[11:7]] <= wb_val;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a short program through the FSM with
// hand-computed expectations, ending with a reset during a store wait state.
module tb_mc_datapath;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     CNT_W    = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h100;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_req, imem_ready;
  logic [XLEN-1:0]  imem_addr;
  logic [31:0]      imem_rdata;
  logic             dmem_req, dmem_we, dmem_ready;
  logic [XLEN-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0]      ir_out;
  logic [2:0]       state_out;
  logic [3:0]       ALU_Control;
  logic [2:0]       ImmSel;
  logic [1:0]       MemtoReg;
  logic             ALUSrc_B, Jump, Branch, InverseBranch, PCOffset, RegWrite, MemRead, MemWrite;
  logic [XLEN-1:0]  pc_out;
  logic             misalign_err;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [4:0]       dbg_addr;
  logic [XLEN-1:0]  dbg_data;

  int nchk  = 0;
  int nfail = 0;

  int          ncyc, mcyc;
  logic [31:0] maddr;
  logic        mstable;

  mc_datapath #(.XLEN(XLEN), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .ir_out(ir_out), .state_out(state_out),
    .ALU_Control(ALU_Control), .ImmSel(ImmSel), .MemtoReg(MemtoReg), .ALUSrc_B(ALUSrc_B),
    .Jump(Jump), .Branch(Branch), .InverseBranch(InverseBranch), .PCOffset(PCOffset),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .pc_out(pc_out), .misalign_err(misalign_err), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic [3:0] alu, input logic [2:0] isel, input logic [1:0] m2r,
                      input logic srcb, input logic jmp, input logic br, input logic inv,
                      input logic pco, input logic rw, input logic mr, input logic mw);
    ALU_Control = alu; ImmSel = isel; MemtoReg = m2r; ALUSrc_B = srcb; Jump = jmp;
    Branch = br; InverseBranch = inv; PCOffset = pco; RegWrite = rw; MemRead = mr; MemWrite = mw;
  endtask

  // Runs one instruction from a FETCH with imem_req high back to the next FETCH
  task automatic exec_instr(input logic [31:0] instr, input int dwait, input logic [31:0] rdata,
                            output int cyc, output int mc, output logic [31:0] addr0,
                            output logic stable);
    int wcnt;
    cyc = 0; mc = 0; wcnt = 0; addr0 = '0; stable = 1'b1;
    imem_rdata = instr;
    imem_ready = 1'b1;
    step();
    cyc = 1;
    imem_ready = 1'b0;
    while (state_out != 3'd0 && cyc < 40) begin
      dmem_ready = 1'b0;
      if (dmem_req) begin
        if (mc == 0) addr0 = dmem_addr;
        else if (dmem_addr !== addr0) stable = 1'b0;
        mc++;
        if (wcnt == dwait) begin
          dmem_ready = 1'b1;
          dmem_rdata = rdata;
        end
        wcnt++;
      end
      step();
      cyc++;
    end
    dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; dmem_rdata = '0; dbg_addr = '0;
    ctrl(4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_pc", pc_out, 32'h100);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_ir", ir_out, 32'd0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_instret", instret_cnt, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    rst = 1'b1;
    step();
    check("first_imem_req", 32'(imem_req), 32'd1);
    check("first_imem_addr", imem_addr, 32'h100);
    check("first_cycle", cycle_cnt, 32'd1);

    // addi x5,x0,7
    ctrl(4'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h00700293, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check("addi_cycles", ncyc, 32'd4);
    check_reg("addi_x5", 5'd5, 32'd7);
    check("addi_pc", pc_out, 32'h104);
    check("addi_instret", instret_cnt, 32'd1);
    check("addi_cycle_cnt", cycle_cnt, 32'd5);

    // lw x6,4(x5) with three wait states
    ctrl(4'd0, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exec_instr(32'h0042A303, 3, 32'hDEADBEEF, ncyc, mcyc, maddr, mstable);
    check("lw_cycles", ncyc, 32'd8);
    check("lw_mem_cycles", mcyc, 32'd4);
    check("lw_addr", maddr, 32'hB);
    check("lw_addr_stable", 32'(mstable), 32'd1);
    check_reg("lw_x6", 5'd6, 32'hDEADBEEF);
    check("lw_pc", pc_out, 32'h108);

    // jal x0,+0xF8 with RegWrite set: x0 stays zero
    ctrl(4'd0, 3'd3, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h0F80006F, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check("jal_pc", pc_out, 32'h200);
    check_reg("jal_x0", 5'd0, 32'd0);

    // bne x5,x5,-8 not taken
    ctrl(4'd1, 3'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exec_instr(32'hFE529CE3, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check("bne_pc", pc_out, 32'h204);

    // jal x0,-4 back to 0x200
    ctrl(4'd0, 3'd3, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exec_instr(32'hFFDFF06F, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check("jal_back_pc", pc_out, 32'h200);

    // beq x0,x0,-8 taken
    ctrl(4'd1, 3'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exec_instr(32'hFE000CE3, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check("beq_pc", pc_out, 32'h1F8);

    // lui x7,1
    ctrl(4'd0, 3'd4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h000013B7, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check_reg("lui_x7", 5'd7, 32'h1000);

    // addi x7,x7,2
    ctrl(4'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h00238393, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check_reg("addi_x7", 5'd7, 32'h1002);
    check("pre_jalr_misalign", 32'(misalign_err), 32'd0);

    // jalr x1,0(x7): bit1 set in the target
    ctrl(4'd0, 3'd0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h000380E7, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check("jalr_pc", pc_out, 32'h1002);
    check_reg("jalr_x1", 5'd1, 32'h204);
    check("jalr_misalign", 32'(misalign_err), 32'd1);

    // addi x0,x0,5 with RegWrite: ignored
    ctrl(4'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h00500013, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check_reg("addi_x0", 5'd0, 32'd0);
    check("sticky_misalign", 32'(misalign_err), 32'd1);

    // sra x8,x6,x5 / sltu x9 / slt x10 / xor x11
    ctrl(4'd7, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h40535433, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check_reg("sra_x8", 5'd8, 32'hFFBD5B7D);
    ctrl(4'd9, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h005334B3, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check_reg("sltu_x9", 5'd9, 32'd0);
    ctrl(4'd8, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h00532533, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check_reg("slt_x10", 5'd10, 32'd1);
    ctrl(4'd4, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h005345B3, 0, 32'h0, ncyc, mcyc, maddr, mstable);
    check_reg("xor_x11", 5'd11, 32'hDEADBEE8);
    check("xor_pc", pc_out, 32'h1016);
    check("xor_instret", instret_cnt, 32'd14);
    check("xor_misalign", 32'(misalign_err), 32'd1);

    // sw x6,8(x5), then reset during its wait state
    ctrl(4'd0, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    imem_rdata = 32'h0062A423;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step(); step();
    check("sw_state", 32'(state_out), 32'd3);
    check("sw_req", 32'(dmem_req), 32'd1);
    check("sw_we", 32'(dmem_we), 32'd1);
    check("sw_addr", dmem_addr, 32'hF);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    step();
    check("sw_wait_req", 32'(dmem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_dmem_req", 32'(dmem_req), 32'd0);
    check("abort_dmem_we", 32'(dmem_we), 32'd0);
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_pc", pc_out, 32'h100);
    check("abort_misalign", 32'(misalign_err), 32'd0);
    check("abort_instret", instret_cnt, 32'd0);
    check_reg("abort_x5", 5'd5, 32'd0);
    check_reg("abort_x6", 5'd6, 32'd0);
    check_reg("abort_x1", 5'd1, 32'd0);
    check_reg("abort_x0", 5'd0, 32'd0);
    step(); step();
    rst = 1'b1;
    step();
    check("restart_imem_req", 32'(imem_req), 32'd1);
    check("restart_imem_addr", imem_addr, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
